// File: rtl/dpram_pkg.sv
// dpram_pkg: shared types and constants for packet-buffer RAM arbitration.
// Imported by the arbiter and its requester-facing helpers.
package dpram_pkg;

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;

  // Low bit of requester k's field in a flattened per-requester bus.
  function automatic int slice_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/dpram_rr_pick.sv
// dpram_rr_pick: combinational round-robin selector.
// Returns the first set request at or after ptr, wrapping.
module dpram_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  int            j;
  logic [IW-1:0] jj;

  // Scan from the far end so the nearest offset wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    jj    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = int'(ptr) + i;
      if (j >= N) begin
        j = j - N;
      end
      jj = IW'(j);
      if (req[jj]) begin
        valid = 1'b1;
        idx   = jj;
      end
    end
  end

endmodule

// File: rtl/dpram_arbiter.sv
// dpram_arbiter: round-robin burst arbiter for the packet-buffer RAM port.
// Owns the port for one burst, generates addresses, tags read returns.
module dpram_arbiter
  import dpram_pkg::*;
#(
  parameter int  NREQ   = 4,
  parameter int  ADDR_W = DEF_ADDR_W,
  parameter int  DATA_W = DEF_DATA_W,
  parameter int  LEN_W  = DEF_LEN_W,
  localparam int IW     = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [NREQ*ADDR_W-1:0] req_addr_i,
  input  logic [NREQ*LEN_W-1:0]  req_len_i,
  input  logic [NREQ*DATA_W-1:0] req_wdata_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      beat_ack_o,
  output logic                 rvalid_o,
  output logic [IW-1:0]        rid_o,
  output logic [DATA_W-1:0]    rdata_o,
  output logic                 busy_o,
  output logic                 ram_en_o,
  output logic                 ram_we_o,
  output logic [ADDR_W-1:0]    ram_addr_o,
  output logic [DATA_W-1:0]    ram_wdata_o,
  input  logic [DATA_W-1:0]    ram_rdata_i
);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     pick_idx;
  logic              pick_valid;
  logic              we;
  logic              first;
  logic              busy;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  cnt;

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [LEN_W-1:0]  len_a   [NREQ];
  logic [DATA_W-1:0] wdata_a [NREQ];

  for (genvar k = 0; k < NREQ; k++) begin : g_unpack
    assign addr_a[k]  = req_addr_i[slice_lo(k, ADDR_W) +: ADDR_W];
    assign len_a[k]   = req_len_i[slice_lo(k, LEN_W) +: LEN_W];
    assign wdata_a[k] = req_wdata_i[slice_lo(k, DATA_W) +: DATA_W];
  end

  dpram_rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .req   (req_i),
    .ptr   (ptr),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign busy = (state == BURST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      owner    <= '0;
      we       <= 1'b0;
      first    <= 1'b0;
      addr     <= '0;
      cnt      <= '0;
      rvalid_o <= 1'b0;
      rid_o    <= '0;
    end else begin
      rvalid_o <= busy && !we;
      rid_o    <= (busy && !we) ? owner : '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            owner <= pick_idx;
            we    <= req_we_i[pick_idx];
            addr  <= addr_a[pick_idx];
            cnt   <= len_a[pick_idx];
            first <= 1'b1;
            ptr   <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
            state <= BURST;
          end
        end
        BURST: begin
          first <= 1'b0;
          addr  <= addr + 1'b1;
          cnt   <= cnt - 1'b1;
          if (cnt == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o      = busy;
  assign ram_en_o    = busy;
  assign ram_we_o    = busy && we;
  assign ram_addr_o  = busy ? addr : '0;
  assign ram_wdata_o = busy ? wdata_a[owner] : '0;
  assign beat_ack_o  = busy ? (NREQ'(1) << owner) : '0;
  assign gnt_o       = first ? (NREQ'(1) << owner) : '0;
  assign rdata_o     = ram_rdata_i;

endmodule

// File: tb/tb_dpram_arbiter.sv
// tb_dpram_arbiter: directed scenarios plus random traffic against a
// cycle-level behavioural model and a RAM shadow.
module tb_dpram_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req, req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*LW-1:0] req_len;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt, ack;
  logic            rvalid, busy, ram_en, ram_we;
  logic [IW-1:0]   rid;
  logic [DW-1:0]   rdata, ram_wdata, ram_rdata;
  logic [AW-1:0]   ram_addr;

  logic [DW-1:0] mem    [256];
  logic [DW-1:0] shadow [256];

  int checks = 0;
  int errors = 0;

  int           m_left, m_owner, m_ptr, m_addr, m_rid;
  bit           m_we, m_first, m_rv, rnd, hold;
  logic [DW-1:0] m_rd;
  logic [N-1:0] seen_gnt, seen_ack;

  dpram_arbiter #(
    .NREQ   (N),
    .ADDR_W (AW),
    .DATA_W (DW),
    .LEN_W  (LW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_len_i   (req_len),
    .req_wdata_i (req_wdata),
    .gnt_o       (gnt),
    .beat_ack_o  (ack),
    .rvalid_o    (rvalid),
    .rid_o       (rid),
    .rdata_o     (rdata),
    .busy_o      (busy),
    .ram_en_o    (ram_en),
    .ram_we_o    (ram_we),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_rdata_i (ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else ram_rdata <= mem[ram_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Requester agents: advance wdata on ack, drop req after grant.
  task automatic drive();
    for (int k = 0; k < N; k++) begin
      if (seen_ack[k])
        req_wdata[k*DW +: DW] = rnd ? DW'($urandom)
                                    : req_wdata[k*DW +: DW] + 1'b1;
      if (seen_gnt[k] && !hold) req[k] = 1'b0;
      if (rnd) begin
        if (!req[k] && $urandom_range(0, 3) == 0) begin
          req[k]              = 1'b1;
          req_we[k]           = ($urandom_range(0, 1) == 1);
          req_addr[k*AW +: AW] = AW'($urandom);
          req_len[k*LW +: LW]  = LW'($urandom_range(0, 5));
        end else if (req[k] && $urandom_range(0, 15) == 0) begin
          req[k] = 1'b0;
        end
        if ($urandom_range(0, 7) == 0)
          req_addr[k*AW +: AW] = AW'($urandom);
      end
    end
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step();
    logic [N-1:0]  eg, ea;
    logic [DW-1:0] wd;
    bit            b;
    drive();
    #1;
    b  = (m_left > 0);
    eg = m_first ? N'(1) << m_owner : '0;
    ea = b ? N'(1) << m_owner : '0;
    wd = b ? req_wdata[m_owner*DW +: DW] : '0;
    chk("busy", 32'(busy), 32'(b));
    chk("ram_en", 32'(ram_en), 32'(b));
    chk("ram_we", 32'(ram_we), 32'(b && m_we));
    chk("ram_addr", 32'(ram_addr), b ? 32'(m_addr) : 32'h0);
    chk("ram_wdata", 32'(ram_wdata), 32'(wd));
    chk("gnt", 32'(gnt), 32'(eg));
    chk("beat_ack", 32'(ack), 32'(ea));
    chk("rvalid", 32'(rvalid), 32'(m_rv));
    if (m_rv) begin
      chk("rid", 32'(rid), 32'(m_rid));
      chk("rdata", 32'(rdata), 32'(m_rd));
    end
    seen_gnt = gnt;
    seen_ack = ack;
    if (b) begin
      if (m_we) shadow[m_addr] = wd;
      else m_rd = shadow[m_addr];
      m_rv    = !m_we;
      m_rid   = m_owner;
      m_addr  = (m_addr + 1) % 256;
      m_left  = m_left - 1;
      m_first = 1'b0;
    end else begin
      m_rv    = 1'b0;
      m_first = 1'b0;
      for (int i = 0; i < N; i++) begin
        int k;
        k = (m_ptr + i) % N;
        if (req[k]) begin
          m_owner = k;
          m_we    = req_we[k];
          m_addr  = int'(req_addr[k*AW +: AW]);
          m_left  = int'(req_len[k*LW +: LW]) + 1;
          m_first = 1'b1;
          m_ptr   = (k + 1) % N;
          break;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ram_en", 32'(ram_en), 32'h0);
    chk("rst_ram_we", 32'(ram_we), 32'h0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_beat_ack", 32'(ack), 32'h0);
    chk("rst_rvalid", 32'(rvalid), 32'h0);
    chk("rst_rid", 32'(rid), 32'h0);
    m_left   = 0;
    m_ptr    = 0;
    m_rv     = 1'b0;
    m_first  = 1'b0;
    seen_gnt = '0;
    seen_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    req = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    rnd = 1'b0; hold = 1'b0;
    seen_gnt = '0; seen_ack = '0;
    m_rd = '0; m_owner = 0; m_addr = 0; m_we = 1'b0; m_rid = 0;
    m_left = 0; m_ptr = 0; m_rv = 1'b0; m_first = 1'b0;
    for (int a = 0; a < 256; a++) begin
      mem[a]    = '0;
      shadow[a] = '0;
    end
    do_reset();

    // Single write by requester 0: A0, A1, A2 at 0x10..0x12.
    req_we[0] = 1'b1; req_addr[0*AW +: AW] = 8'h10;
    req_len[0*LW +: LW] = 4'd2; req_wdata[0*DW +: DW] = 8'hA0;
    req[0] = 1'b1;
    repeat (6) step();
    chk("write_mem_11", 32'(mem[8'h11]), 32'hA1);

    // Read back by requester 2.
    req_we[2] = 1'b0; req_addr[2*AW +: AW] = 8'h10;
    req_len[2*LW +: LW] = 4'd2; req[2] = 1'b1;
    repeat (6) step();

    // Contention from reset, requests held.
    do_reset();
    hold = 1'b1;
    for (int k = 0; k < N; k++) begin
      req_we[k] = 1'b0;
      req_len[k*LW +: LW] = 4'd0;
      req_addr[k*AW +: AW] = AW'(8'h10 + k);
    end
    req = '1;
    for (int c = 0; c < 16; c++) begin
      step();
      if (c % 2 == 1)
        chk("rr_order", 32'(seen_gnt), 32'(N'(1) << ((c / 2) % N)));
    end
    hold = 1'b0;
    req = '0;
    repeat (3) step();

    // Address wrap: write then read 0xFE..0x01.
    req_we[1] = 1'b1; req_addr[1*AW +: AW] = 8'hFE;
    req_len[1*LW +: LW] = 4'd3; req[1] = 1'b1;
    repeat (6) step();
    req_we[3] = 1'b0; req_addr[3*AW +: AW] = 8'hFE;
    req_len[3*LW +: LW] = 4'd3; req[3] = 1'b1;
    repeat (7) step();

    // Mid-burst changes to addr/len/req are ignored.
    req_we[0] = 1'b1; req_addr[0*AW +: AW] = 8'h40;
    req_len[0*LW +: LW] = 4'd4; req[0] = 1'b1;
    step();
    step();
    req_addr[0*AW +: AW] = 8'h80;
    req_len[0*LW +: LW] = 4'd1;
    repeat (7) step();

    // Reset during beat 2 of a 4-beat read.
    req_we[2] = 1'b0; req_addr[2*AW +: AW] = 8'h40;
    req_len[2*LW +: LW] = 4'd3; req[2] = 1'b1;
    step();
    step();
    do_reset();
    req_we = '0;
    for (int k = 0; k < N; k++) req_len[k*LW +: LW] = 4'd0;
    req = '1;
    step();
    step();
    chk("rst_next_gnt", 32'(seen_gnt), 32'h1);
    repeat (8) step();

    // Random traffic.
    rnd = 1'b1;
    repeat (3000) step();
    rnd = 1'b0;
    req = '0;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpram_arbiter.md
# dpram_arbiter

Round-robin burst arbiter that shares the single write/read port of the packet-buffer dual-port RAM between up to NREQ requesters (packet builder, CRC appender, host-side readback). It sits between the requester agents and the dpram_if signal bundle. It owns the RAM port for one burst at a time, generates incrementing addresses, and returns read data tagged with the owner's ID.

## Interface
- NREQ, 4, number of requesters (2..8)
- ADDR_W, 8, RAM address width
- DATA_W, 8, RAM data width
- LEN_W, 4, burst-length field width (beats minus 1)

- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- req_i  in  NREQ  per-requester burst request; held until matching gnt_o
- req_we_i  in  NREQ  1 = write burst, 0 = read burst
- req_addr_i  in  NREQ*ADDR_W  start address, requester k at slice k
- req_len_i  in  NREQ*LEN_W  beats minus 1
- req_wdata_i  in  NREQ*DATA_W  current write beat per requester
- gnt_o  out  NREQ  one-hot, one-cycle pulse when a burst is accepted
- beat_ack_o  out  NREQ  one-hot; the owner's beat is consumed this cycle, so advance wdata
- rvalid_o  out  1  read data valid
- rid_o  out  $clog2(NREQ)  owner of returned read beat
- rdata_o  out  DATA_W  read data
- busy_o  out  1  burst in progress
- ram_en_o, ram_we_o  out  1  RAM port enable / write enable
- ram_addr_o  out  ADDR_W  RAM address
- ram_wdata_o  out  DATA_W  RAM write data
- ram_rdata_i  in  DATA_W  RAM read data, valid one cycle after a read enable

## Operation
- States: IDLE, BURST.
- IDLE with any req_i set:
  - Pick the first set bit at or after pointer ptr, wrapping.
  - On the clock edge, latch owner, we, addr and cnt=len; go to BURST.
  - Set ptr = (owner+1) mod NREQ.
- BURST, every cycle:
  - ram_en_o=1, ram_we_o=latched we, ram_addr_o=cur_addr, ram_wdata_o = owner's req_wdata_i slice.
  - beat_ack_o[owner]=1.
  - cur_addr increments mod 2^ADDR_W (0xFF wraps to 0x00).
  - cnt decrements; the cycle with cnt==0 is the last beat, after which the state returns to IDLE.
- gnt_o[owner] pulses in the first BURST cycle only.
- busy_o = (state==BURST).
- Read return: rvalid_o and rid_o are registered from (BURST && !we) and owner; rdata_o = ram_rdata_i passed through.
- Changes to req_i, req_addr_i or req_len_i during a burst are ignored; the burst always runs len+1 beats.
- A requester whose req_i drops before grant is simply not selected. No error is raised.
- ptr advances only on a grant, giving fair rotation among active requesters.
- In IDLE, all RAM and beat outputs are 0.

## Timing
- Reset (async assert, sync release) values:
  - state=IDLE, ptr=0.
  - gnt_o, beat_ack_o, rvalid_o, rid_o, busy_o, ram_en_o, ram_we_o, ram_addr_o, ram_wdata_o all 0.
- Arbitration latency: req_i seen in IDLE at cycle N produces gnt_o and the first beat at N+1.
- Burst of L beats occupies cycles N+1..N+L.
- At least one IDLE cycle between consecutive bursts, so port utilisation is L/(L+1).
- Read data: rvalid_o appears one cycle after each read beat. The last rvalid_o lands in the first IDLE cycle.
- Reset mid-burst aborts immediately:
  - pending rvalid is dropped;
  - no further beats are issued;
  - ptr returns to 0.
- Simultaneous requests from all NREQ: grants go in order ptr, ptr+1, … wrapping.

## Structure
- Shared package dpram_pkg holds:
  - the state enum (IDLE, BURST);
  - default ADDR_W, DATA_W, LEN_W constants;
  - a function for the flattened-bus slice index.
- One sub-module, dpram_rr_pick: combinational round-robin selector. Inputs req and ptr; outputs valid and idx. It is reusable by other buffer arbiters.
- Everything else (FSM, counters, address generator, read-tag register) lives in dpram_arbiter.

## Test plan
- Single write: req 0, addr 0x10, len 2, data A,B,C. Required: gnt_o[0] at N+1; RAM writes 0x10/A, 0x11/B, 0x12/C on N+1..N+3; beat_ack_o[0] high those 3 cycles; IDLE at N+4.
- Single read: req 2, addr 0x10, len 2 after the write above. Required: rvalid_o at N+2..N+4 with rid_o=2 and rdata_o A,B,C.
- Contention: all four requesters request len 0 from reset. Required: grants 0,1,2,3 on alternating cycles; ptr returns to 0; then 0 again if still requesting.
- Address wrap: addr 0xFE, len 3. Required: ram_addr_o sequence 0xFE, 0xFF, 0x00, 0x01.
- Mid-burst changes: req_i dropped and req_addr_i changed during the burst. Required: the burst completes with its original length and addresses.
- Reset mid-read-burst: rst_n low during beat 2 of 4. Required: all outputs 0 immediately; no rvalid_o after release; next grant goes to requester 0.
